// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int unsigned OVERSAMPLE    = 16;
  localparam int unsigned SAMPLE_MID_LO = 7;
  localparam int unsigned SAMPLE_MID_HI = 9;
  localparam int unsigned DATA_BITS     = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO; head register holds the last value once drained.
module uart_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp, rp, count;
  logic             do_rd, do_wr;

  assign count = wp - rp;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (wp == rp);
  assign do_rd = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_wr) wp <= wp + (AW+1)'(1);
      if (do_rd) rp <= rp + (AW+1)'(1);
    end
  end

  // Head register: load the incoming word when it becomes the head, else the next stored entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (do_wr && (empty || (do_rd && count == (AW+1)'(1)))) begin
      rd_data <= wr_data;
    end else if (do_rd && count > (AW+1)'(1)) begin
      rd_data <= mem[rp[AW-1:0] + AW'(1)];
    end
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x oversampling 8N1 UART receiver with 3-sample majority vote and receive FIFO.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_TICK = 27,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       fifo_full,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);
  rx_state_t      state, state_nx;
  logic           rx_meta, rxs;
  logic [15:0]    tick_cnt;
  logic           tick, decide, bit_end, maj;
  logic [3:0]     s;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic           v_lo, v_mid;
  logic           push, frame_err_nx, overrun_nx, fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign tick    = (state != IDLE) && (tick_cnt == 16'(CLKS_PER_TICK - 1));
  assign decide  = tick && (s == 4'(SAMPLE_MID_HI));
  assign bit_end = tick && (s == 4'(OVERSAMPLE - 1));
  // Third vote is the live sample taken on the decision tick itself.
  assign maj     = maj3(v_lo, v_mid, rxs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      s        <= '0;
      v_lo     <= 1'b1;
      v_mid    <= 1'b1;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      if (state == IDLE)  tick_cnt <= '0;
      else if (tick)      tick_cnt <= '0;
      else                tick_cnt <= tick_cnt + 16'd1;

      if (state == IDLE)  s <= '0;
      else if (tick)      s <= s + 4'd1;

      if (tick && s == 4'(SAMPLE_MID_LO))     v_lo  <= rxs;
      if (tick && s == 4'(SAMPLE_MID_LO + 1)) v_mid <= rxs;

      if (state == START)                 bit_idx <= '0;
      else if (state == DATA && bit_end)  bit_idx <= bit_idx + 3'd1;

      if (state == DATA && decide) shift <= {maj, shift[7:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nx;
      frame_err <= frame_err_nx;
      overrun   <= overrun_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    push         = 1'b0;
    frame_err_nx = 1'b0;
    overrun_nx   = 1'b0;
    case (state)
      IDLE:  if (!rxs) state_nx = START;
      START: begin
        if (decide && maj) state_nx = IDLE;
        else if (bit_end)  state_nx = DATA;
      end
      DATA:  if (bit_end && bit_idx == 3'(DATA_BITS - 1)) state_nx = STOP;
      STOP: begin
        // Leave at the mid-stop decision so a following start edge is not missed.
        if (decide) begin
          state_nx = IDLE;
          if (!maj)                     frame_err_nx = 1'b1;
          else if (!fifo_full || rd_en) push         = 1'b1;
          else                          overrun_nx   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign rd_valid = !fifo_empty;

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (shift),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: doc/uart_rx_oversample.md
# uart_rx_oversample

Receive-side UART core that pairs with the transmitter path of `tt_um_uart`. It samples the asynchronous `rx` line at 16× the bit rate and uses a 3-sample majority vote per bit. It frames 8N1 characters and buffers good bytes in a small show-ahead FIFO read by the host-side logic. Frame errors and overruns are reported as single-cycle pulses.

## Interface
- `CLKS_PER_TICK`, default 27: `clk` cycles per oversample tick; bit period is `16*CLKS_PER_TICK` clocks; legal range 2..65535.
- `FIFO_DEPTH`, default 4: receive FIFO entries; must be a power of two, ≥2.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `rx` in 1: asynchronous serial input; idle high.
- `rd_en` in 1: pops the FIFO head; ignored when `rd_valid`=0.
- `rd_data` out 8: FIFO head (show-ahead); reset 8'h00; holds last value when empty.
- `rd_valid` out 1: FIFO not empty; reset 0.
- `fifo_full` out 1: count == FIFO_DEPTH; reset 0.
- `busy` out 1: FSM not in IDLE; reset 0.
- `frame_err` out 1: 1-cycle pulse, stop bit sampled 0; reset 0.
- `overrun` out 1: 1-cycle pulse, good byte dropped because FIFO full; reset 0.

## Operation
- `rx` passes a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `rxs`.
- Tick generator: counter 0..CLKS_PER_TICK-1, `tick` asserted on terminal count. Only runs when FSM ≠ IDLE; cleared on IDLE exit.
- Sample counter `s` counts 0..15 per bit, advancing on `tick`.
- Majority: on `tick` with s=7,8,9, capture `rxs`. Bit value = majority of the 3; evaluated on the s=9 tick.
- IDLE: `rxs`=0 → START, tick counter and `s` cleared.
- START: at the s=9 decision, majority=1 → false start, back to IDLE (no flags). Otherwise continue to s=15 tick → DATA, bit index 0.
- DATA: at each s=9 decision, shift the majority value in LSB-first. At the s=15 tick, if index=7 → STOP, else index+1.
- STOP: at the s=9 decision:
  - majority=1 and FIFO not full → push byte.
  - majority=1 and FIFO full → `overrun` pulse; byte dropped.
  - majority=0 → `frame_err` pulse; byte dropped.
  - In all three cases → IDLE immediately (not waiting for s=15), so back-to-back frames with one stop bit are captured.
- A break (rx held low) yields one `frame_err`, then IDLE re-detects low and produces a `frame_err` every ~10 bit times until `rx` returns high.
- FIFO: write and read pointers of width log2(FIFO_DEPTH)+1, wrapping naturally.
  - Push and pop in the same cycle: if count is between 1 and DEPTH-1, both occur and count is unchanged.
  - When full, a same-cycle pop frees the slot, so the push is accepted; no `overrun`.
  - When empty, a push with `rd_en` does not pop (no fall-through).
- Reset mid-frame: FSM → IDLE, FIFO emptied, partial byte discarded, flags low.

## Timing
- Start edge to IDLE exit: 2 cycles of synchronizer plus 1 cycle of edge detection.
- STOP decision tick at ≈ 9 bit times + 10 ticks after IDLE exit.
- The push is registered: `rd_valid` and `rd_data` update 1 cycle after the decision tick, and `frame_err`/`overrun` pulse in that same cycle.
- `rd_en` at cycle t: `rd_data` shows the next entry at t+1, and `rd_valid` drops at t+1 if the FIFO becomes empty.
- `busy` is high from IDLE exit through the STOP decision cycle.

## Structure
- Package `uart_pkg`:
  - `rx_state_t` enum {IDLE, START, DATA, STOP}
  - `OVERSAMPLE`=16
  - `SAMPLE_MID_LO`=7, `SAMPLE_MID_HI`=9
  - `DATA_BITS`=8
- Sub-module `uart_sync_fifo` (parameterized DEPTH/WIDTH, show-ahead, `full`/`empty` outputs), instantiated once. Synchronizer, tick generator and FSM are inline.

## Test plan
All scenarios use CLKS_PER_TICK=4 (bit = 64 clocks).
- Drive 8'hA5 as 8N1 → `rd_valid`=1, `rd_data`=8'hA5; no flags; `rd_en` pulse → `rd_valid`=0.
- Send 0x00, 0xFF, 0x55 back-to-back with one stop bit each → three entries read in order, no flags.
- Low glitch of 20 clocks on an idle line → false start; `busy` returns 0, FIFO empty, no flags.
- Frame 0x3C with the stop bit driven 0 → exactly one `frame_err` pulse; FIFO still empty.
- FIFO_DEPTH=4: send 5 bytes 0x01..0x05 with no reads → `fifo_full`=1, one `overrun` on the 5th byte, and reads return 0x01..0x04. Repeat with `rd_en` asserted on the 5th push cycle → no `overrun`.
- Assert `rst_n`=0 during data bit 3 of a frame → all outputs at reset values. After release, a fresh 8'h81 frame is received correctly.
